// File: rtl/game_counter_param.sv
// ----------------------------------------------------------------------------
// game_counter_param
//
// Parametrised multi-mode up/down game counter. The counter steps by 1 or by
// BIG_STEP in either direction when enabled. Each enabled step that lands on
// all-ones scores a win and each that lands on all-zeros scores a lose. The
// first score to reach WIN_LIMIT raises gameover/who for GO_HOLD cycles while
// everything else is frozen. The game then restarts from a cleared state.
//
// Optional feature macro: SCORE_OUT_EN
//   defined   -> win_score / lose_score outputs are present after `who`
//   undefined -> scores stay internal; behaviour is otherwise identical
//
// Parameters
//   WIDTH      counter width (>= 2), wraps modulo 2**WIDTH
//   SCORE_W    width of the win/lose score registers
//   WIN_LIMIT  score that ends the game (1 .. 2**SCORE_W-1)
//   BIG_STEP   step for modes 01/11 (1 .. 2**WIDTH-1)
//   GO_HOLD    cycles gameover/who stay asserted (>= 1)
//
// Ports
//   clk         in   rising-edge clock
//   reset       in   asynchronous active-low reset
//   en          in   count enable
//   control     in   00 +1, 01 +BIG_STEP, 10 -1, 11 -BIG_STEP
//   init        in   synchronous load of init_value (wins over en)
//   init_value  in   load value
//   count_out   out  registered counter value
//   gameover    out  game ended, held for GO_HOLD cycles
//   who         out  01 win limit hit, 10 lose limit hit, else 00
//   win_score   out  registered win score  (SCORE_OUT_EN only)
//   lose_score  out  registered lose score (SCORE_OUT_EN only)
// ----------------------------------------------------------------------------
module game_counter_param #(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned SCORE_W   = 4,
    parameter int unsigned WIN_LIMIT = 15,
    parameter int unsigned BIG_STEP  = 2,
    parameter int unsigned GO_HOLD   = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic [1:0]         control,
    input  logic               init,
    input  logic [WIDTH-1:0]   init_value,
    output logic [WIDTH-1:0]   count_out,
    output logic               gameover,
    output logic [1:0]         who
`ifdef SCORE_OUT_EN
    ,
    output logic [SCORE_W-1:0] win_score,
    output logic [SCORE_W-1:0] lose_score
`endif
);

    localparam logic [0:0] PLAY = 1'b0;
    localparam logic [0:0] OVER = 1'b1;

    // Hold counter only needs to reach GO_HOLD-1.
    localparam int unsigned HOLD_W = (GO_HOLD > 1) ? $clog2(GO_HOLD) : 1;

    localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(GO_HOLD - 1);
    localparam logic [SCORE_W-1:0] LIMIT     = SCORE_W'(WIN_LIMIT);
    localparam logic [WIDTH-1:0]   STEP_BIG  = WIDTH'(BIG_STEP);
    localparam logic [WIDTH-1:0]   STEP_ONE  = WIDTH'(1);

    localparam logic [1:0] WHO_NONE = 2'b00;
    localparam logic [1:0] WHO_WIN  = 2'b01;
    localparam logic [1:0] WHO_LOSE = 2'b10;

    logic [0:0]         state_q, state_d;
    logic [WIDTH-1:0]   count_q, count_d;
    logic [SCORE_W-1:0] win_score_q, win_score_d;
    logic [SCORE_W-1:0] lose_score_q, lose_score_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic               gameover_q, gameover_d;
    logic [1:0]         who_q, who_d;

    logic [WIDTH-1:0]   step;
    logic [WIDTH-1:0]   stepped;
    logic [SCORE_W-1:0] win_inc;
    logic [SCORE_W-1:0] lose_inc;

    // Candidate next count; wrap-around falls out of the fixed width.
    always_comb begin
        step     = control[0] ? STEP_BIG : STEP_ONE;
        stepped  = control[1] ? (count_q - step) : (count_q + step);
        win_inc  = win_score_q + SCORE_W'(1);
        lose_inc = lose_score_q + SCORE_W'(1);
    end

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        win_score_d  = win_score_q;
        lose_score_d = lose_score_q;
        hold_d       = hold_q;
        gameover_d   = gameover_q;
        who_d        = who_q;

        case (state_q)
            PLAY: begin
                if (init) begin
                    // Loads never score, whatever the value.
                    count_d = init_value;
                end else if (en) begin
                    count_d = stepped;
                    if (&stepped) begin
                        win_score_d = win_inc;
                        if (win_inc == LIMIT) begin
                            gameover_d = 1'b1;
                            who_d      = WHO_WIN;
                            hold_d     = '0;
                            state_d    = OVER;
                        end
                    end else if (stepped == '0) begin
                        lose_score_d = lose_inc;
                        if (lose_inc == LIMIT) begin
                            gameover_d = 1'b1;
                            who_d      = WHO_LOSE;
                            hold_d     = '0;
                            state_d    = OVER;
                        end
                    end
                end
            end

            OVER: begin
                // init/en ignored; count and scores frozen.
                if (hold_q == HOLD_LAST) begin
                    // Restart clears the counter; this zero is not a lose.
                    gameover_d   = 1'b0;
                    who_d        = WHO_NONE;
                    count_d      = '0;
                    win_score_d  = '0;
                    lose_score_d = '0;
                    hold_d       = '0;
                    state_d      = PLAY;
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end

            default: begin
                state_d = PLAY;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= PLAY;
            count_q      <= '0;
            win_score_q  <= '0;
            lose_score_q <= '0;
            hold_q       <= '0;
            gameover_q   <= 1'b0;
            who_q        <= WHO_NONE;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            win_score_q  <= win_score_d;
            lose_score_q <= lose_score_d;
            hold_q       <= hold_d;
            gameover_q   <= gameover_d;
            who_q        <= who_d;
        end
    end

    assign count_out = count_q;
    assign gameover  = gameover_q;
    assign who       = who_q;

`ifdef SCORE_OUT_EN
    assign win_score  = win_score_q;
    assign lose_score = lose_score_q;
`endif

endmodule

// File: tb/tb_game_counter_param.sv
// ----------------------------------------------------------------------------
// tb_game_counter_param
//
// Directed bench for game_counter_param. Two instances share all stimulus:
// `dut` uses the default parameters and `dut_h3` uses GO_HOLD=3. Both see the
// same history, so they diverge only once a game-over hold starts.
// Score values are observed through the score outputs when SCORE_OUT_EN is
// defined, otherwise through the internal score registers.
// ----------------------------------------------------------------------------
module tb_game_counter_param;

    logic       clk;
    logic       reset;
    logic       en;
    logic [1:0] control;
    logic       init;
    logic [3:0] init_value;

    logic [3:0] count_out, count_out_h3;
    logic       gameover, gameover_h3;
    logic [1:0] who, who_h3;
    logic [3:0] win_obs, lose_obs;

    int vectors;
    int miscompares;

`ifdef SCORE_OUT_EN
    logic [3:0] win_score_h3, lose_score_h3;
`endif

    game_counter_param dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .control    (control),
        .init       (init),
        .init_value (init_value),
        .count_out  (count_out),
        .gameover   (gameover),
        .who        (who)
`ifdef SCORE_OUT_EN
        ,
        .win_score  (win_obs),
        .lose_score (lose_obs)
`endif
    );

    game_counter_param #(
        .GO_HOLD (3)
    ) dut_h3 (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .control    (control),
        .init       (init),
        .init_value (init_value),
        .count_out  (count_out_h3),
        .gameover   (gameover_h3),
        .who        (who_h3)
`ifdef SCORE_OUT_EN
        ,
        .win_score  (win_score_h3),
        .lose_score (lose_score_h3)
`endif
    );

`ifndef SCORE_OUT_EN
    assign win_obs  = dut.win_score_q;
    assign lose_obs = dut.lose_score_q;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock edge; inputs change and outputs are sampled 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b0;
        en          = 1'b0;
        control     = 2'b00;
        init        = 1'b0;
        init_value  = 4'd0;

        // Reset state
        #12;
        check("rst_count", 32'(count_out), 32'd0);
        check("rst_gameover", 32'(gameover), 32'd0);
        check("rst_who", 32'(who), 32'd0);
        check("rst_win", 32'(win_obs), 32'd0);
        check("rst_lose", 32'(lose_obs), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        tick();

        // Load then count up onto all-ones
        init = 1'b1; init_value = 4'd14;
        tick();
        check("load14", 32'(count_out), 32'd14);
        init = 1'b0; en = 1'b1; control = 2'b00;
        tick();
        check("up_to15", 32'(count_out), 32'd15);
        check("win_after_15", 32'(win_obs), 32'd1);

        // Idle edge: nothing moves
        en = 1'b0;
        tick();
        check("idle_count", 32'(count_out), 32'd15);
        check("idle_win", 32'(win_obs), 32'd1);

        // -BIG_STEP wraps 1 -> 15 (win); 2 -> 0 (lose)
        init = 1'b1; init_value = 4'd1;
        tick();
        init = 1'b0; en = 1'b1; control = 2'b11;
        tick();
        check("down2_wrap", 32'(count_out), 32'd15);
        check("win_wrap", 32'(win_obs), 32'd2);
        init = 1'b1; en = 1'b0; init_value = 4'd2;
        tick();
        init = 1'b0; en = 1'b1;
        tick();
        check("down2_zero", 32'(count_out), 32'd0);
        check("lose_zero", 32'(lose_obs), 32'd1);

        // +BIG_STEP 13 -> 15
        init = 1'b1; en = 1'b0; init_value = 4'd13;
        tick();
        init = 1'b0; en = 1'b1; control = 2'b01;
        tick();
        check("up2_15", 32'(count_out), 32'd15);
        check("win_up2", 32'(win_obs), 32'd3);

        // init beats en; loads of 15 / 0 do not score
        init = 1'b1; en = 1'b1; control = 2'b00; init_value = 4'd15;
        tick();
        check("init_pri15", 32'(count_out), 32'd15);
        check("init15_noscore", 32'(win_obs), 32'd3);
        init_value = 4'd0;
        tick();
        check("init_pri0", 32'(count_out), 32'd0);
        check("init0_noscore", 32'(lose_obs), 32'd1);

        // Async reset mid-count (count 9, win 3), seen before the next edge
        init_value = 4'd9; en = 1'b0;
        tick();
        init = 1'b0;
        check("pre_rst_count", 32'(count_out), 32'd9);
        #2;
        reset = 1'b0;
        #1;
        check("async_count", 32'(count_out), 32'd0);
        check("async_gameover", 32'(gameover), 32'd0);
        check("async_who", 32'(who), 32'd0);
        check("async_win", 32'(win_obs), 32'd0);
        check("async_lose", 32'(lose_obs), 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // Win limit: +1 held from 0, 15th win on enabled edge 239
        init = 1'b1; init_value = 4'd0;
        tick();
        init = 1'b0; en = 1'b1; control = 2'b00;
        ticks(238);
        check("pre_win_gameover", 32'(gameover), 32'd0);
        check("pre_win_count", 32'(count_out), 32'd14);
        check("pre_win_score", 32'(win_obs), 32'd14);
        tick();
        check("win_gameover", 32'(gameover), 32'd1);
        check("win_who", 32'(who), 32'd1);
        check("win_count", 32'(count_out), 32'd15);
        check("win_limit_score", 32'(win_obs), 32'd15);
        check("win_lose_score", 32'(lose_obs), 32'd14);
        check("h3_win_gameover", 32'(gameover_h3), 32'd1);
        tick();
        check("restart_count", 32'(count_out), 32'd0);
        check("restart_gameover", 32'(gameover), 32'd0);
        check("restart_who", 32'(who), 32'd0);
        check("restart_win", 32'(win_obs), 32'd0);
        check("restart_lose", 32'(lose_obs), 32'd0);
        check("h3_hold1_gameover", 32'(gameover_h3), 32'd1);
        check("h3_hold1_count", 32'(count_out_h3), 32'd15);
        tick();
        check("after_restart_count", 32'(count_out), 32'd1);
        check("h3_hold2_gameover", 32'(gameover_h3), 32'd1);
        check("h3_hold2_who", 32'(who_h3), 32'd1);
        check("h3_hold2_count", 32'(count_out_h3), 32'd15);
        tick();
        check("h3_release_gameover", 32'(gameover_h3), 32'd0);
        check("h3_release_who", 32'(who_h3), 32'd0);
        check("h3_release_count", 32'(count_out_h3), 32'd0);
        tick();
        check("h3_first_en", 32'(count_out_h3), 32'd1);

        // Lose limit: -1 held from 15, 15th lose on enabled edge 239
        en = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        init = 1'b1; init_value = 4'd15;
        tick();
        init = 1'b0; en = 1'b1; control = 2'b10;
        ticks(238);
        check("pre_lose_gameover", 32'(gameover), 32'd0);
        tick();
        check("lose_gameover", 32'(gameover), 32'd1);
        check("lose_who", 32'(who), 32'd2);
        check("lose_count", 32'(count_out), 32'd0);
        check("lose_limit_score", 32'(lose_obs), 32'd15);
        check("lose_win_score", 32'(win_obs), 32'd14);
        tick();
        check("lose_restart_gameover", 32'(gameover), 32'd0);
        check("lose_restart_score", 32'(lose_obs), 32'd0);

        // -1 from 1: lose 1, then 16 more edges -> win 1, lose 2
        en = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        init = 1'b1; init_value = 4'd1;
        tick();
        init = 1'b0; en = 1'b1; control = 2'b10;
        tick();
        check("dn_zero_count", 32'(count_out), 32'd0);
        check("dn_zero_lose", 32'(lose_obs), 32'd1);
        ticks(16);
        check("dn16_count", 32'(count_out), 32'd0);
        check("dn16_lose", 32'(lose_obs), 32'd2);
        check("dn16_win", 32'(win_obs), 32'd1);
`ifdef SCORE_OUT_EN
        check("h3_port_lose", 32'(lose_score_h3), 32'd2);
        check("h3_port_win", 32'(win_score_h3), 32'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
